// File: rtl/row_window_buffer.sv
// Three-row line buffer that emits a vertical 3-tap pixel column (rows y-1, y, y+1) per accepted pixel.
// Define ROW_WINDOW_EDGE_ZERO_EN to drive out-of-frame taps to zero instead of replicating the centre row.
module row_window_buffer #(
  parameter int PIX_W    = 24,
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PIX_W-1:0]              pixel_in,
  input  logic                          in_sof,
  output logic                          out_valid,
  output logic [PIX_W-1:0]              out_top,
  output logic [PIX_W-1:0]              out_mid,
  output logic [PIX_W-1:0]              out_bot,
  output logic [$clog2(H_ACTIVE)-1:0]   out_x,
  output logic [$clog2(V_ACTIVE)-1:0]   out_y,
  output logic                          out_eof
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t          state_reg;
  logic [XW-1:0]   wx_reg, fx_reg, out_x_reg;
  logic [YW-1:0]   wy_reg, out_y_reg;
  logic [1:0]      wb_reg;          // bank holding row wy (wy mod 3)
  logic [1:0]      mid_sel_reg, top_sel_reg;
  logic            top_edge_reg, bot_edge_reg;
  logic [PIX_W-1:0] bot_pix_reg;
  logic            out_valid_reg, out_eof_reg;

  function automatic logic [1:0] dec3(input logic [1:0] b);
    return (b == 2'd0) ? 2'd2 : b - 2'd1;
  endfunction

  logic          accept, resync;
  logic [1:0]    wr_bank, mid_bank, top_bank;
  logic [XW-1:0] wr_addr, rd_addr;

  assign in_ready = !reset && (state_reg != FLUSH);
  assign accept   = in_valid && in_ready;
  assign resync   = accept && in_sof;
  assign wr_bank  = resync ? 2'd0 : wb_reg;
  assign wr_addr  = resync ? '0 : wx_reg;
  assign rd_addr  = (state_reg == FLUSH) ? fx_reg : wx_reg;
  assign mid_bank = dec3(wb_reg);
  assign top_bank = dec3(mid_bank);

  logic [PIX_W-1:0] rd_data [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_bank
      logic [PIX_W-1:0] mem [H_ACTIVE];
      logic [PIX_W-1:0] rd_reg;

      always_ff @(posedge clk) begin
        if (accept && wr_bank == 2'(gi))
          mem[wr_addr] <= pixel_in;
      end

      always_ff @(posedge clk) begin
        if (reset)
          rd_reg <= '0;
        else
          rd_reg <= mem[rd_addr];
      end

      assign rd_data[gi] = rd_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= FILL;
      wx_reg        <= '0;
      wy_reg        <= '0;
      fx_reg        <= '0;
      wb_reg        <= 2'd0;
      out_valid_reg <= 1'b0;
      out_eof_reg   <= 1'b0;
      out_x_reg     <= '0;
      out_y_reg     <= '0;
      mid_sel_reg   <= 2'd0;
      top_sel_reg   <= 2'd0;
      top_edge_reg  <= 1'b0;
      bot_edge_reg  <= 1'b0;
      bot_pix_reg   <= '0;
    end else begin
      out_valid_reg <= 1'b0;
      out_eof_reg   <= 1'b0;
      case (state_reg)
        FILL, RUN: begin
          if (accept) begin
            if (in_sof) begin
              // Restart as pixel (0,0); the window already in flight still leaves next cycle.
              state_reg <= FILL;
              wx_reg    <= XW'(1);
              wy_reg    <= '0;
              wb_reg    <= 2'd0;
            end else begin
              if (state_reg == RUN) begin
                out_valid_reg <= 1'b1;
                out_x_reg     <= wx_reg;
                out_y_reg     <= wy_reg - YW'(1);
                mid_sel_reg   <= mid_bank;
                top_sel_reg   <= top_bank;
                top_edge_reg  <= (wy_reg == YW'(1));
                bot_edge_reg  <= 1'b0;
                bot_pix_reg   <= pixel_in;
              end
              if (wx_reg == X_LAST) begin
                wx_reg <= '0;
                wy_reg <= wy_reg + YW'(1);
                wb_reg <= (wb_reg == 2'd2) ? 2'd0 : wb_reg + 2'd1;
                if (state_reg == FILL) begin
                  state_reg <= RUN;
                end else if (wy_reg == Y_LAST) begin
                  state_reg <= FLUSH;
                  fx_reg    <= '0;
                end
              end else begin
                wx_reg <= wx_reg + XW'(1);
              end
            end
          end
        end
        FLUSH: begin
          // wb_reg has already advanced past the last row, so the RUN bank mapping still holds.
          out_valid_reg <= 1'b1;
          out_x_reg     <= fx_reg;
          out_y_reg     <= Y_LAST;
          mid_sel_reg   <= mid_bank;
          top_sel_reg   <= top_bank;
          top_edge_reg  <= 1'b0;
          bot_edge_reg  <= 1'b1;
          out_eof_reg   <= (fx_reg == X_LAST);
          if (fx_reg == X_LAST) begin
            state_reg <= FILL;
            wx_reg    <= '0;
            wy_reg    <= '0;
            fx_reg    <= '0;
            wb_reg    <= 2'd0;
          end else begin
            fx_reg <= fx_reg + XW'(1);
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  logic [PIX_W-1:0] mid_val, top_val;

  always_comb begin
    mid_val = rd_data[0];
    top_val = rd_data[0];
    case (mid_sel_reg)
      2'd1:    mid_val = rd_data[1];
      2'd2:    mid_val = rd_data[2];
      default: mid_val = rd_data[0];
    endcase
    case (top_sel_reg)
      2'd1:    top_val = rd_data[1];
      2'd2:    top_val = rd_data[2];
      default: top_val = rd_data[0];
    endcase
  end

  assign out_valid = out_valid_reg;
  assign out_eof   = out_eof_reg;
  assign out_x     = out_x_reg;
  assign out_y     = out_y_reg;
  assign out_mid   = mid_val;
`ifdef ROW_WINDOW_EDGE_ZERO_EN
  assign out_top   = top_edge_reg ? '0 : top_val;
  assign out_bot   = bot_edge_reg ? '0 : bot_pix_reg;
`else
  assign out_top   = top_edge_reg ? mid_val : top_val;
  assign out_bot   = bot_edge_reg ? mid_val : bot_pix_reg;
`endif

endmodule

// File: tb/tb_row_window_buffer.sv
// Scoreboard bench for row_window_buffer: the driver queues expected windows, a monitor pops and compares.
module tb_row_window_buffer;
  localparam int PW = 8;
  localparam int H  = 4;
  localparam int V  = 3;
`ifdef ROW_WINDOW_EDGE_ZERO_EN
  localparam bit EZ = 1'b1;
`else
  localparam bit EZ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [PW-1:0] pixel_in = '0;
  logic          in_ready, out_valid, out_eof;
  logic [PW-1:0] out_top, out_mid, out_bot;
  logic [1:0]    out_x, out_y;

  row_window_buffer #(.PIX_W(PW), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pixel_in(pixel_in), .in_sof(in_sof), .out_valid(out_valid),
    .out_top(out_top), .out_mid(out_mid), .out_bot(out_bot),
    .out_x(out_x), .out_y(out_y), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          x;
    int          y;
    logic [7:0]  t;
    logic [7:0]  m;
    logic [7:0]  b;
    bit          eof;
    int          at;
  } win_t;

  win_t exp_q[$];
  win_t mon_w;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] pv(input int x, input int y);
    return 8'(16 * y + x);
  endfunction

  // Expected window centred on row y at column x, arriving at negedge number 'at'.
  task automatic push_win(input int x, input int y, input int at);
    win_t w;
    w.x   = x;
    w.y   = y;
    w.m   = pv(x, y);
    w.t   = (y == 0) ? (EZ ? 8'h00 : pv(x, y)) : pv(x, y - 1);
    w.b   = (y == V - 1) ? (EZ ? 8'h00 : pv(x, y)) : pv(x, y + 1);
    w.eof = (x == H - 1) && (y == V - 1);
    w.at  = at;
    exp_q.push_back(w);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_window got x=%0d y=%0d top=%h mid=%h bot=%h eof=%0b cyc=%0d, none expected",
                 out_x, out_y, out_top, out_mid, out_bot, out_eof, cyc);
      end else begin
        mon_w = exp_q.pop_front();
        if (int'(out_x) != mon_w.x || int'(out_y) != mon_w.y || out_top !== mon_w.t ||
            out_mid !== mon_w.m || out_bot !== mon_w.b || out_eof !== mon_w.eof || cyc != mon_w.at) begin
          errors++;
          $display("FAIL window(%0d,%0d) got x=%0d y=%0d top=%h mid=%h bot=%h eof=%0b cyc=%0d, want top=%h mid=%h bot=%h eof=%0b cyc=%0d",
                   mon_w.x, mon_w.y, out_x, out_y, out_top, out_mid, out_bot, out_eof, cyc,
                   mon_w.t, mon_w.m, mon_w.b, mon_w.eof, mon_w.at);
        end else begin
          $display("ok window(%0d,%0d) top=%h mid=%h bot=%h eof=%0b cyc=%0d",
                   out_x, out_y, out_top, out_mid, out_bot, out_eof, cyc);
        end
      end
    end
  end

  // Presents a pixel and holds it until in_ready; acc is the negedge before the accepting edge.
  task automatic send_pix(input int x, input int y, input bit sof, output int acc, output int waited);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    pixel_in = pv(x, y);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout pixel(%0d,%0d) got in_ready=0 after %0d cycles, want 1", x, y, n);
    end
    waited = n;
    acc    = cyc;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic frame_px(input int x, input int y, input bit sof, input int flush_n,
                          output int acc, output int waited);
    send_pix(x, y, sof, acc, waited);
    if (y >= 1)
      push_win(x, y - 1, acc + 1);
    if (x == H - 1 && y == V - 1)
      for (int k = 0; k < flush_n; k++)
        push_win(k, V - 1, acc + 2 + k);
  endtask

  task automatic send_frame(input bit gap, input int flush_n, output int last_acc, output int first_wait);
    int acc, wt;
    first_wait = 0;
    last_acc   = 0;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        if (gap && !(x == 0 && y == 0))
          idle();
        frame_px(x, y, (x == 0 && y == 0), flush_n, acc, wt);
        if (x == 0 && y == 0)
          first_wait = wt;
      end
    end
    last_acc = acc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish by 200000, want earlier finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last, fw, acc, wt;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_eof !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got in_ready=%0b out_valid=%0b out_eof=%0b, want 0 0 0", in_ready, out_valid, out_eof);
    end
    checks++;
    if (out_top !== 8'h00 || out_mid !== 8'h00 || out_bot !== 8'h00 || out_x !== 2'd0 || out_y !== 2'd0) begin
      errors++;
      $display("FAIL reset_data got top=%h mid=%h bot=%h x=%0d y=%0d, want all 0", out_top, out_mid, out_bot, out_x, out_y);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %0b, want 1", in_ready);
    end

    // Two back-to-back continuous frames; the second waits out the 4-cycle flush.
    send_frame(1'b0, 4, last, fw);
    send_frame(1'b0, 4, last, fw);
    checks++;
    if (fw != 4) begin
      errors++;
      $display("FAIL flush_ready_low got %0d cycles, want 4", fw);
    end

    // Alternating valid/idle cycles.
    idle();
    send_frame(1'b1, 4, last, fw);

    // Abort after pixel (0,1): the next pixel carries sof and starts a fresh frame.
    idle();
    frame_px(0, 0, 1'b1, 4, acc, wt);
    frame_px(1, 0, 1'b0, 4, acc, wt);
    frame_px(2, 0, 1'b0, 4, acc, wt);
    frame_px(3, 0, 1'b0, 4, acc, wt);
    frame_px(0, 1, 1'b0, 4, acc, wt);
    send_frame(1'b0, 4, last, fw);

    // Reset while the flush counter sits at 1: only the fx=0 window escapes.
    send_frame(1'b0, 1, last, fw);
    idle();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_flush got out_valid=%0b in_ready=%0b, want 0 0", out_valid, in_ready);
    end
    reset = 1'b0;
    send_frame(1'b0, 4, last, fw);

    idle();
    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_windows got %0d still pending, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
